// File: rtl/int_fp_pkg.sv
// Shared types and field layout for the sequential integer-to-float converter.
package int_fp_pkg;

    localparam int unsigned INT_W_DEF  = 16;
    localparam int unsigned EXP_W_DEF  = 5;
    localparam int unsigned FRAC_W_DEF = 8;
    localparam int unsigned FP_W_DEF   = 1 + EXP_W_DEF + FRAC_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        RND  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Total packed width of {sign, exp, frac}
    function automatic int unsigned fp_w(input int unsigned exp_w, input int unsigned frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    // Bit index of the sign field in the packed result
    function automatic int unsigned sign_pos(input int unsigned exp_w, input int unsigned frac_w);
        return exp_w + frac_w;
    endfunction

    // Bit index of the exponent MSB in the packed result
    function automatic int unsigned exp_msb(input int unsigned exp_w, input int unsigned frac_w);
        return exp_w + frac_w - 1;
    endfunction

endpackage

// File: rtl/int_to_fp_seq_fp_round.sv
// Combinational significand extraction with optional round-half-up.
module fp_round
    import int_fp_pkg::*;
#(
    parameter int unsigned MAG_W  = INT_W_DEF - 1,
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic [MAG_W-1:0]  mag,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic              round_en,
    output logic [FRAC_W-1:0] frac,
    output logic [EXP_W-1:0]  exp_out
);

    if (FRAC_W >= MAG_W) begin : g_pad
        // Significand wide enough: left-justify magnitude, no rounding needed
        logic unused_round_en;
        assign unused_round_en = round_en;

        always_comb begin
            frac    = FRAC_W'(mag) << (FRAC_W - MAG_W);
            exp_out = exp_in;
        end
    end else begin : g_round
        logic [FRAC_W-1:0] trunc_c;
        logic              guard_c;
        logic [FRAC_W:0]   sum_c;

        assign trunc_c = mag[MAG_W-1 -: FRAC_W];
        assign guard_c = mag[MAG_W-1-FRAC_W];
        assign sum_c   = {1'b0, trunc_c} + (FRAC_W+1)'(round_en && guard_c);

        if (MAG_W - 1 - FRAC_W > 0) begin : g_low
            // Bits below the guard do not affect round-half-up
            logic unused_low;
            assign unused_low = ^mag[MAG_W-2-FRAC_W:0];
        end

        // Carry out of the significand renormalises to 0.1000.. with exp+1
        always_comb begin
            frac    = sum_c[FRAC_W-1:0];
            exp_out = exp_in;
            if (sum_c[FRAC_W]) begin
                frac             = '0;
                frac[FRAC_W-1]   = 1'b1;
                exp_out          = exp_in + EXP_W'(1);
            end
        end
    end

endmodule

// File: rtl/int_to_fp_seq.sv
// Sequential sign-magnitude integer to {sign, exp, frac} converter with
// one-bit-per-cycle normalisation and valid/ready handshakes.
module int_to_fp_seq
    import int_fp_pkg::*;
#(
    parameter int unsigned INT_W  = INT_W_DEF,
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INT_W-1:0]          int_in,
    input  logic                      round_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1+EXP_W+FRAC_W-1:0] fp_out,
    output logic                      busy
);

    localparam int unsigned MAG_W    = INT_W - 1;
    localparam int unsigned FP_W     = fp_w(EXP_W, FRAC_W);
    localparam int unsigned SIGN_POS = sign_pos(EXP_W, FRAC_W);
    localparam int unsigned EXP_MSB  = exp_msb(EXP_W, FRAC_W);

    state_t             state_q;
    state_t             state_d;
    logic               sign_q;
    logic [MAG_W-1:0]   mag_q;
    logic [EXP_W-1:0]   exp_q;
    logic               rnd_q;
    logic [FRAC_W-1:0]  frac_rnd_c;
    logic [EXP_W-1:0]   exp_rnd_c;
    logic [FP_W-1:0]    fp_q;
    logic               norm_done_c;
    logic               accept_c;

    assign accept_c    = (state_q == IDLE) && in_valid && in_ready;
    assign norm_done_c = (mag_q == '0) || mag_q[MAG_W-1];
    assign fp_out      = fp_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = NORM;
            NORM:    if (norm_done_c) state_d = RND;
            RND:     state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and iterative normalisation
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sign_q <= 1'b0;
            mag_q  <= '0;
            exp_q  <= '0;
            rnd_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        sign_q <= int_in[INT_W-1];
                        mag_q  <= int_in[INT_W-2:0];
                        exp_q  <= EXP_W'(MAG_W);
                        rnd_q  <= round_en;
                    end
                end
                NORM: begin
                    if (mag_q == '0) begin
                        exp_q <= '0;
                    end else if (!mag_q[MAG_W-1]) begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - EXP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    fp_round #(
        .MAG_W  (MAG_W),
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_fp_round (
        .mag      (mag_q),
        .exp_in   (exp_q),
        .round_en (rnd_q),
        .frac     (frac_rnd_c),
        .exp_out  (exp_rnd_c)
    );

    // Registered handshake/status outputs and result capture in RND
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            fp_q      <= '0;
        end else begin
            in_ready  <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            out_valid <= (state_d == OUT);
            if (state_q == RND) begin
                fp_q[SIGN_POS]             <= sign_q;
                fp_q[EXP_MSB -: EXP_W]     <= exp_rnd_c;
                fp_q[FRAC_W-1:0]           <= frac_rnd_c;
            end
        end
    end

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Directed self-checking bench for int_to_fp_seq at default parameters.
module tb_int_to_fp_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] int_in;
    logic        round_en;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] fp_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    int_to_fp_seq #(
        .INT_W  (16),
        .EXP_W  (5),
        .FRAC_W (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .int_in    (int_in),
        .round_en  (round_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_out    (fp_out),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] v, input logic r, input string tag);
        @(negedge clk);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        int_in   = v;
        round_en = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        int_in   = 16'hDEAD;
        round_en = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, " idle"},    32'(busy),      32'd0);
        check({tag, " rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic convert(input logic [15:0] v, input logic r, input logic [13:0] exp_fp,
                           input int exp_lat, input string tag);
        int n;
        start_op(v, r, tag);
        wait_out(n);
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " fp_out"}, 32'(fp_out), 32'(exp_fp));
        release_out(tag);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        int_in    = 16'h0000;
        round_en  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst fp_out",    32'(fp_out),    32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        convert(16'h0001, 1'b0, {1'b0, 5'd1,  8'h80}, 16, "p1");
        convert(16'h8000, 1'b0, {1'b1, 5'd0,  8'h00}, 2,  "neg0");
        convert(16'h0000, 1'b0, {1'b0, 5'd0,  8'h00}, 2,  "zero");
        convert(16'h0024, 1'b0, {1'b0, 5'd6,  8'h90}, 11, "p36");
        convert(16'h8181, 1'b0, {1'b1, 5'd9,  8'hC0}, 8,  "n385_trunc");
        convert(16'h8181, 1'b1, {1'b1, 5'd9,  8'hC1}, 8,  "n385_rnd");
        convert(16'h7FFF, 1'b0, {1'b0, 5'd15, 8'hFF}, 2,  "max_trunc");
        convert(16'h7FFF, 1'b1, {1'b0, 5'd16, 8'h80}, 2,  "max_rnd_ovf");

        // Backpressure: result held, new operands ignored
        start_op(16'h0024, 1'b0, "bp");
        wait_out(lat);
        check("bp latency", 32'(lat), 32'd11);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            int_in   = 16'h0001;
            @(posedge clk);
            #1;
            check("bp hold fp_out",    32'(fp_out),    32'({1'b0, 5'd6, 8'h90}));
            check("bp hold out_valid", 32'(out_valid), 32'd1);
            check("bp hold in_ready",  32'(in_ready),  32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out("bp");
        @(posedge clk);
        #1;
        check("bp no stray accept", 32'(busy), 32'd0);
        check("bp fp_out kept",     32'(fp_out), 32'({1'b0, 5'd6, 8'h90}));

        // Reset in the middle of normalisation
        start_op(16'h0001, 1'b0, "mid_rst");
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst busy before", 32'(busy), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst busy",      32'(busy),      32'd0);
        check("mid_rst out_valid", 32'(out_valid), 32'd0);
        check("mid_rst fp_out",    32'(fp_out),    32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        convert(16'h0024, 1'b0, {1'b0, 5'd6, 8'h90}, 11, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
